noise_regs: RTL and testbench

NOISE_REGS -- requirements
Module: noise_regs

---
 rtl/noise_regs.sv | 134 +++++++++++++
 tb/tb_noise_regs.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/noise_regs.sv
// Noise-channel register file (NR41..NR44) with field decode, trigger pulse and readback.
// Define NOISE_REG_READBACK_EN to build the readback mux; otherwise rdata is constant 8'hFF.
module noise_regs #(
  parameter int unsigned TRIG_HOLD = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       apuOn,
  input  logic [1:0] addr,
  input  logic       wr,
  input  logic [7:0] wdata,
  input  logic       rd,
  output logic [7:0] rdata,
  output logic       rvalid,
  output logic [5:0] lenLoad,
  output logic       lenStrobe,
  output logic [3:0] startVol,
  output logic       envAdd,
  output logic [2:0] envPeriod,
  output logic [3:0] clkShift,
  output logic       widthMode,
  output logic [2:0] divisor,
  output logic       lenEnable,
  output logic       trigger,
  output logic       dacOn
);

  localparam logic [3:0] HOLD = 4'(TRIG_HOLD);

  logic [5:0] nr41_q, nr41_d;
  logic [7:0] nr42_q, nr42_d;
  logic [7:0] nr43_q, nr43_d;
  logic       nr44_len_q, nr44_len_d;
  logic [3:0] trig_cnt_q, trig_cnt_d;
  logic       len_strobe_q, len_strobe_d;
  logic       rvalid_q, rvalid_d;

  // Read handshake: rd is a single-cycle request with no back-pressure; rvalid
  // pulses for exactly one cycle after each rd cycle and rdata holds until the next read.
  always_comb begin
    nr41_d       = nr41_q;
    nr42_d       = nr42_q;
    nr43_d       = nr43_q;
    nr44_len_d   = nr44_len_q;
    trig_cnt_d   = trig_cnt_q;
    len_strobe_d = apuOn & wr & (addr == 2'd0);
    rvalid_d     = rd;
    if (!apuOn) begin
      nr41_d     = '0;
      nr42_d     = '0;
      nr43_d     = '0;
      nr44_len_d = 1'b0;
      trig_cnt_d = '0;
    end else begin
      if (trig_cnt_q != 4'd0) trig_cnt_d = trig_cnt_q - 4'd1;
      if (wr) begin
        case (addr)
          2'd0: nr41_d = wdata[5:0];
          2'd1: begin
            nr42_d = wdata;
            // Silencing the DAC kills any pulse in flight.
            if (wdata[7:3] == 5'd0) trig_cnt_d = '0;
          end
          2'd2: nr43_d = wdata;
          default: begin
            nr44_len_d = wdata[6];
            // Reload rather than restart so back-to-back triggers merge into one pulse.
            if (wdata[7] && (nr42_q[7:3] != 5'd0) && (nr42_d[7:3] != 5'd0)) trig_cnt_d = HOLD;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      nr41_q       <= '0;
      nr42_q       <= '0;
      nr43_q       <= '0;
      nr44_len_q   <= 1'b0;
      trig_cnt_q   <= '0;
      len_strobe_q <= 1'b0;
      rvalid_q     <= 1'b0;
    end else begin
      nr41_q       <= nr41_d;
      nr42_q       <= nr42_d;
      nr43_q       <= nr43_d;
      nr44_len_q   <= nr44_len_d;
      trig_cnt_q   <= trig_cnt_d;
      len_strobe_q <= len_strobe_d;
      rvalid_q     <= rvalid_d;
    end
  end

`ifdef NOISE_REG_READBACK_EN
  logic [7:0] rdata_q, rdata_d;

  // Mux reads the pre-write register contents, so rd+wr to one address returns the old value.
  always_comb begin
    rdata_d = rdata_q;
    if (rd) begin
      case (addr)
        2'd0:    rdata_d = 8'hFF;
        2'd1:    rdata_d = apuOn ? nr42_q : 8'h00;
        2'd2:    rdata_d = apuOn ? nr43_q : 8'h00;
        default: rdata_d = {1'b1, apuOn & nr44_len_q, 6'h3F};
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rdata_q <= '0;
    else        rdata_q <= rdata_d;
  end

  assign rdata = rdata_q;
`else
  assign rdata = 8'hFF;
`endif

  assign rvalid    = rvalid_q;
  assign lenLoad   = nr41_q;
  assign lenStrobe = len_strobe_q;
  assign startVol  = nr42_q[7:4];
  assign envAdd    = nr42_q[3];
  assign envPeriod = nr42_q[2:0];
  assign clkShift  = nr43_q[7:4];
  assign widthMode = nr43_q[3];
  assign divisor   = nr43_q[2:0];
  assign lenEnable = nr44_len_q;
  assign trigger   = (trig_cnt_q != 4'd0);
  assign dacOn     = (nr42_q[7:3] != 5'd0);

endmodule

// File: tb/tb_noise_regs.sv
// Bench for noise_regs: byte-level register model with a timestamped trigger window,
// per-cycle compare on the falling edge, plus literal checks. Honours NOISE_REG_READBACK_EN.
module tb_noise_regs;
  localparam int TH = 3;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       apuOn, wr, rd;
  logic [1:0] addr;
  logic [7:0] wdata;
  logic [7:0] rdata;
  logic       rvalid, lenStrobe, envAdd, widthMode, lenEnable, trigger, dacOn;
  logic [5:0] lenLoad;
  logic [3:0] startVol, clkShift;
  logic [2:0] envPeriod, divisor;

  noise_regs #(.TRIG_HOLD(TH)) dut (
    .clk(clk), .rst_n(rst_n), .apuOn(apuOn), .addr(addr), .wr(wr), .wdata(wdata),
    .rd(rd), .rdata(rdata), .rvalid(rvalid), .lenLoad(lenLoad), .lenStrobe(lenStrobe),
    .startVol(startVol), .envAdd(envAdd), .envPeriod(envPeriod), .clkShift(clkShift),
    .widthMode(widthMode), .divisor(divisor), .lenEnable(lenEnable), .trigger(trigger),
    .dacOn(dacOn)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Model: stored register bytes as they would read back unmasked, trigger as a cycle window.
  logic [7:0] m_reg [4];
  int         cyc = 0;
  int         trig_until = 0;
  logic       m_strobe, m_rvalid;
  logic [7:0] m_rdata;
  bit         chk_en = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] read_view(input logic [1:0] a, input logic apu);
    case (a)
      2'd0:    return 8'hFF;
      2'd1:    return apu ? m_reg[1] : 8'h00;
      2'd2:    return apu ? m_reg[2] : 8'h00;
      default: return {1'b1, apu & m_reg[3][6], 6'h3F};
    endcase
  endfunction

  function automatic logic [7:0] exp_rdata();
`ifdef NOISE_REG_READBACK_EN
    return m_rdata;
`else
    return 8'hFF;
`endif
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_reg[i] = 8'h00;
    trig_until = 0;
    m_strobe   = 1'b0;
    m_rvalid   = 1'b0;
    m_rdata    = 8'h00;
  endtask

  // One clock: drive inputs, predict the post-edge state, commit it at the edge.
  task automatic step(input logic a_apu, input logic a_wr, input logic a_rd,
                      input logic [1:0] a_addr, input logic [7:0] a_wdata);
    logic [7:0] nr [4];
    int         ntu;
    int         edge_no;
    logic       n_strobe;
    logic [7:0] n_rdata;
    nr       = m_reg;
    ntu      = trig_until;
    edge_no  = cyc + 1;
    apuOn    = a_apu;
    wr       = a_wr;
    rd       = a_rd;
    addr     = a_addr;
    wdata    = a_wdata;
    n_strobe = a_apu & a_wr & (a_addr == 2'd0);
    n_rdata  = a_rd ? read_view(a_addr, a_apu) : m_rdata;
    if (!a_apu) begin
      for (int i = 0; i < 4; i++) nr[i] = 8'h00;
      ntu = 0;
    end else if (a_wr) begin
      case (a_addr)
        2'd0: nr[0] = {2'b00, a_wdata[5:0]};
        2'd1: begin
          nr[1] = a_wdata;
          if (a_wdata[7:3] == 5'd0) ntu = 0;
        end
        2'd2: nr[2] = a_wdata;
        default: begin
          nr[3] = {1'b0, a_wdata[6], 6'b0};
          if (a_wdata[7] && m_reg[1][7:3] != 5'd0) ntu = edge_no + TH;
        end
      endcase
    end
    @(posedge clk);
    m_reg      = nr;
    trig_until = ntu;
    m_strobe   = n_strobe;
    m_rvalid   = a_rd;
    m_rdata    = n_rdata;
    cyc        = edge_no;
    #1;
  endtask

  task automatic idle(input logic a_apu);
    step(a_apu, 1'b0, 1'b0, 2'd0, 8'h00);
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("lenLoad",   lenLoad,   m_reg[0][5:0]);
      chk("lenStrobe", lenStrobe, m_strobe);
      chk("startVol",  startVol,  m_reg[1][7:4]);
      chk("envAdd",    envAdd,    m_reg[1][3]);
      chk("envPeriod", envPeriod, m_reg[1][2:0]);
      chk("clkShift",  clkShift,  m_reg[2][7:4]);
      chk("widthMode", widthMode, m_reg[2][3]);
      chk("divisor",   divisor,   m_reg[2][2:0]);
      chk("lenEnable", lenEnable, m_reg[3][6]);
      chk("dacOn",     dacOn,     m_reg[1][7:3] != 5'd0);
      chk("trigger",   trigger,   cyc < trig_until);
      chk("rvalid",    rvalid,    m_rvalid);
      chk("rdata",     rdata,     exp_rdata());
    end
  end

  int  hi;
  logic [7:0] rb_ff, rb_bf, rb_a5, rb_00, rst_rd;

  initial begin
`ifdef NOISE_REG_READBACK_EN
    rb_ff = 8'hFF; rb_bf = 8'hBF; rb_a5 = 8'hA5; rb_00 = 8'h00; rst_rd = 8'h00;
`else
    rb_ff = 8'hFF; rb_bf = 8'hFF; rb_a5 = 8'hFF; rb_00 = 8'hFF; rst_rd = 8'hFF;
`endif
    rst_n = 1'b0; apuOn = 1'b0; wr = 1'b0; rd = 1'b0; addr = 2'd0; wdata = 8'h00;
    model_reset();
    #22;
    chk("rst_trigger",   trigger,   1'b0);
    chk("rst_lenStrobe", lenStrobe, 1'b0);
    chk("rst_rvalid",    rvalid,    1'b0);
    chk("rst_dacOn",     dacOn,     1'b0);
    chk("rst_rdata",     rdata,     rst_rd);
    @(posedge clk); #1;
    rst_n  = 1'b1;
    chk_en = 1;
    idle(1'b1);

    step(1, 1, 0, 2'd1, 8'hF3);
    chk("f3_startVol",  startVol,  4'hF);
    chk("f3_envAdd",    envAdd,    1'b0);
    chk("f3_envPeriod", envPeriod, 3'd3);
    chk("f3_dacOn",     dacOn,     1'b1);

    step(1, 1, 0, 2'd1, 8'h80);
    step(1, 1, 0, 2'd3, 8'hC0);
    chk("trig_first", trigger, 1'b1);
    chk("trig_len",   lenEnable, 1'b1);
    hi = 1;
    repeat (4) begin idle(1'b1); hi += int'(trigger); end
    chk("trig_width", hi, 3);

    step(1, 1, 0, 2'd1, 8'h07);
    chk("dac_off", dacOn, 1'b0);
    step(1, 1, 0, 2'd3, 8'h80);
    hi = int'(trigger);
    repeat (3) begin idle(1'b1); hi += int'(trigger); end
    chk("trig_suppressed", hi, 0);
    chk("suppr_len", lenEnable, 1'b0);

    step(1, 1, 0, 2'd0, 8'hFF);
    chk("nr41_lenLoad", lenLoad,   6'h3F);
    chk("nr41_strobe",  lenStrobe, 1'b1);
    step(1, 0, 1, 2'd0, 8'h00);
    chk("nr41_strobe_end", lenStrobe, 1'b0);
    chk("nr41_rvalid",     rvalid,    1'b1);
    chk("nr41_rdata",      rdata,     8'hFF);
    idle(1'b1);
    chk("rvalid_one", rvalid, 1'b0);

    step(1, 1, 0, 2'd1, 8'h80);
    step(1, 1, 0, 2'd3, 8'hC0);
    step(1, 0, 1, 2'd3, 8'h00);
    chk("nr44_rd_c0", rdata, rb_ff);
    step(1, 1, 0, 2'd3, 8'h00);
    step(1, 0, 1, 2'd3, 8'h00);
    chk("nr44_rd_00", rdata, rb_bf);
    repeat (4) idle(1'b1);

    step(1, 1, 0, 2'd3, 8'h80);
    hi = int'(trigger);
    idle(1'b1); hi += int'(trigger);
    step(1, 1, 0, 2'd3, 8'h80); hi += int'(trigger);
    repeat (4) begin idle(1'b1); hi += int'(trigger); end
    chk("trig_extend", hi, 5);

    step(1, 1, 0, 2'd3, 8'h80);
    chk("cancel_pre", trigger, 1'b1);
    step(1, 1, 0, 2'd1, 8'h00);
    chk("cancel_trig", trigger, 1'b0);

    step(1, 1, 0, 2'd1, 8'hA5);
    step(1, 1, 1, 2'd1, 8'h3C);
    chk("rdwr_old",   rdata,    rb_a5);
    chk("rdwr_write", startVol, 4'h3);

    step(1, 1, 0, 2'd1, 8'hF0);
    step(1, 1, 0, 2'd3, 8'h80);
    chk("apu_pre", trigger, 1'b1);
    idle(1'b0);
    chk("apu_trig", trigger, 1'b0);
    chk("apu_dac",  dacOn,   1'b0);
    step(0, 1, 0, 2'd2, 8'h5A);
    chk("apu_nr43", clkShift, 4'h0);
    step(0, 0, 1, 2'd2, 8'h00);
    chk("apu_rd2",  rdata,  rb_00);
    chk("apu_rv",   rvalid, 1'b1);
    step(0, 0, 1, 2'd3, 8'h00);
    chk("apu_rd3",  rdata,  rb_bf);
    step(0, 1, 0, 2'd0, 8'hFF);
    chk("apu_strobe", lenStrobe, 1'b0);

    step(1, 1, 0, 2'd1, 8'hF0);
    step(1, 1, 0, 2'd3, 8'hC0);
    chk("rst_mid_pre", trigger, 1'b1);
    chk_en = 0;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_trig", trigger,   1'b0);
    chk("rst_mid_len",  lenEnable, 1'b0);
    chk("rst_mid_dac",  dacOn,     1'b0);
    model_reset();
    wr = 1'b0; rd = 1'b0;
    @(posedge clk); #1;
    rst_n  = 1'b1;
    chk_en = 1;
    idle(1'b1);
    chk("rel_trig",   trigger,   1'b0);
    chk("rel_strobe", lenStrobe, 1'b0);
    chk("rel_rvalid", rvalid,    1'b0);
    idle(1'b1);

    @(negedge clk);
    chk_en = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
